// File: rtl/player_input_ctrl.sv
// rtl/player_input_ctrl.sv - player answer capture, ranking and memory-slot writer
module player_input_ctrl #(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 16,
  parameter int P_BASE        = 32,
  parameter int DEB_CYCLES    = 50000,
  parameter int DEB_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               btn,
  input  logic [15:0]              ans,
  input  logic                     round_clr,
  input  logic                     flag_clr,
  output logic                     mem_wr_req,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic                     mem_wr_ack,
  output logic                     player_flag,
  output logic [3:0]               locked,
  output logic [1:0]               winner,
  output logic                     winner_valid
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic [3:0]          btn_s1, btn_s2;
  logic [15:0]         ans_s1, ans_s2;
  logic [DEB_BITS-1:0] cnt [4];
  logic [3:0]          press;
  logic [3:0]          pending;
  logic [3:0]          ans_q [4];
  logic [1:0]          grant, rank, pick;

  // A press fires on the single cycle the counter steps onto DEB_CYCLES.
  always_comb begin
    press = 4'b0;
    for (int i = 0; i < 4; i++)
      press[i] = btn_s2[i] && (cnt[i] == DEB_BITS'(DEB_CYCLES - 1));
  end

  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (pending[i]) pick = 2'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 4'b0;
      btn_s2 <= 4'b0;
      ans_s1 <= 16'b0;
      ans_s2 <= 16'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      ans_s1 <= ans;
      ans_s2 <= ans_s1;
      for (int i = 0; i < 4; i++) begin
        if (!btn_s2[i])
          cnt[i] <= '0;
        else if (cnt[i] != DEB_BITS'(DEB_CYCLES))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pending      <= 4'b0;
      locked       <= 4'b0;
      rank         <= 2'd0;
      grant        <= 2'd0;
      mem_wr_req   <= 1'b0;
      mem_adr      <= '0;
      mem_wdata    <= '0;
      player_flag  <= 1'b0;
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      for (int i = 0; i < 4; i++) ans_q[i] <= 4'b0;
    end else if (round_clr) begin
      // An ack landing here is dropped; the CPU re-initialises the slots anyway.
      state        <= IDLE;
      pending      <= 4'b0;
      locked       <= 4'b0;
      rank         <= 2'd0;
      mem_wr_req   <= 1'b0;
      player_flag  <= 1'b0;
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      for (int i = 0; i < 4; i++) ans_q[i] <= 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press[i] && !locked[i]) begin
          pending[i] <= 1'b1;
          locked[i]  <= 1'b1;
          ans_q[i]   <= ans_s2[4*i +: 4];
        end
      end
      if (flag_clr) player_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (pending != 4'b0) begin
            grant      <= pick;
            mem_adr    <= RAM_ADDR_BITS'(P_BASE) + RAM_ADDR_BITS'(pick);
            mem_wdata  <= {1'b1, rank, {(WIDTH-7){1'b0}}, ans_q[pick]};
            mem_wr_req <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_wr_ack) begin
            // grant is already locked, so no new press can collide with this clear.
            pending[grant] <= 1'b0;
            mem_wr_req     <= 1'b0;
            player_flag    <= 1'b1;
            if (rank == 2'd0) begin
              winner       <= grant;
              winner_valid <= 1'b1;
            end
            rank  <= rank + 2'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
